sign_narrow_stream: RTL

Streaming signed narrowing unit, the inverse of the immediate sign-extension path: takes M-bit two's-complement words and produces N-bit words.
- Flags every word that does not fit in N bits and keeps a running overflow count.
- Valid/ready on both sides; elastic 1-cycle pipeline (output register + skid buffer), sustains full throughput.
- Sits between wide datapath results and narrow immediate/field writers (e.g. re-encoding 32-bit values into 12-bit immediates).

---
 rtl/sign_narrow_stream.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sign_narrow_stream.sv
// Streaming signed narrowing M -> N bits with overflow flag, saturating overflow counter
// and an elastic output register plus skid entry. Define SIGN_NARROW_SAT_EN to clamp overflowed words.
module sign_narrow_stream #(
   parameter int N     = 12,
   parameter int M     = 32,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [M-1:0]     i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [N-1:0]     o_data,
   output logic             o_ovf,
   output logic [CNT_W-1:0] o_ovf_cnt
);

   generate
      if (M <= N) begin : g_bad_width
         $error("sign_narrow_stream: M must be greater than N");
      end
   endgenerate

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // A word fits when every bit from the new sign position upward equals the sign.
   logic [M-N:0] top_bits;
   logic         in_ovf;
   logic [N-1:0] in_data;

   assign top_bits = i_data[M-1:N-1];
   assign in_ovf   = !((&top_bits) || !(|top_bits));

`ifdef SIGN_NARROW_SAT_EN
   always_comb begin
      in_data = i_data[N-1:0];
      if (in_ovf) begin
         in_data = i_data[M-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end
   end
`else
   assign in_data = i_data[N-1:0];
`endif

   logic [N-1:0]     out_data_q, out_data_d;
   logic             out_ovf_q, out_ovf_d;
   logic             out_valid_q, out_valid_d;
   logic [N-1:0]     skid_data_q, skid_data_d;
   logic             skid_ovf_q, skid_ovf_d;
   logic             skid_valid_q, skid_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             acc, pop;

   assign acc = i_valid && !skid_valid_q;
   assign pop = out_valid_q && i_ready;

   always_comb begin
      out_data_d   = out_data_q;
      out_ovf_d    = out_ovf_q;
      out_valid_d  = out_valid_q;
      skid_data_d  = skid_data_q;
      skid_ovf_d   = skid_ovf_q;
      skid_valid_d = skid_valid_q;
      cnt_d        = cnt_q;

      if (!out_valid_q) begin
         if (acc) begin
            out_data_d  = in_data;
            out_ovf_d   = in_ovf;
            out_valid_d = 1'b1;
         end
      end else if (!skid_valid_q) begin
         if (pop && acc) begin
            out_data_d = in_data;
            out_ovf_d  = in_ovf;
         end else if (pop) begin
            out_valid_d = 1'b0;
         end else if (acc) begin
            skid_data_d  = in_data;
            skid_ovf_d   = in_ovf;
            skid_valid_d = 1'b1;
         end
      end else if (pop) begin
         out_data_d   = skid_data_q;
         out_ovf_d    = skid_ovf_q;
         skid_valid_d = 1'b0;
      end

      if (pop && out_ovf_q && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         out_data_q   <= '0;
         out_ovf_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         skid_data_q  <= '0;
         skid_ovf_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         out_data_q   <= out_data_d;
         out_ovf_q    <= out_ovf_d;
         out_valid_q  <= out_valid_d;
         skid_data_q  <= skid_data_d;
         skid_ovf_q   <= skid_ovf_d;
         skid_valid_q <= skid_valid_d;
         cnt_q        <= cnt_d;
      end
   end

   // Ready depends only on skid occupancy, so there is no path from i_ready.
   assign o_ready   = !skid_valid_q;
   assign o_valid   = out_valid_q;
   assign o_data    = out_data_q;
   assign o_ovf     = out_ovf_q;
   assign o_ovf_cnt = cnt_q;

endmodule
